// File: rtl/multi_cycle_cpu_if.sv
// Memory bus between the multi-cycle core (master) and instruction/data memory (slave).
// A transfer completes in any cycle where MemReq and MemReady are both high.
interface multi_cycle_cpu_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              MemReq;
    logic              MemWr;
    logic [ADDR_W-1:0] MemAddr;
    logic [31:0]       MemWData;
    logic [31:0]       MemRData;
    logic              MemReady;

    modport master (
        output MemReq,
        output MemWr,
        output MemAddr,
        output MemWData,
        input  MemRData,
        input  MemReady
    );

    modport slave (
        input  MemReq,
        input  MemWr,
        input  MemAddr,
        input  MemWData,
        output MemRData,
        output MemReady
    );
endinterface

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// One shared memory port; HALT is sticky until Reset.
module multi_cycle_cpu #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                Clock,
    input  logic                Reset,
    multi_cycle_cpu_if.master   mem,
    output logic                Halted,
    output logic [CNT_W-1:0]    RetireCnt
);

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       ir_q, a_q, b_q, alu_q, mdr_q;
    logic [31:0]       rf_q [32];
    logic [CNT_W-1:0]  cnt_q;

    // Instruction fields
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] sext_imm;

    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};

    logic [31:0]       alu_res;
    logic              retire;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_next;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       rf_wdata;

    assign Halted       = (state_q == StHalt);
    assign RetireCnt    = cnt_q;
    assign mem.MemWData = b_q;

    // Next-state, ALU, bus outputs and writeback controls decoded from the current state
    always_comb begin
        state_d     = state_q;
        alu_res     = '0;
        retire      = 1'b0;
        pc_load     = 1'b0;
        pc_next     = pc_q;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        mem.MemReq  = 1'b0;
        mem.MemWr   = 1'b0;
        mem.MemAddr = pc_q;

        unique case (state_q)
            StFetch: begin
                mem.MemReq = 1'b1;
                if (mem.MemReady) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = StExec;
            end
            StExec: begin
                case (opcode)
                    OpRtype: begin
                        state_d = StWb;
                        case (funct)
                            FnAdd:   alu_res = a_q + b_q;
                            FnSub:   alu_res = a_q - b_q;
                            FnAnd:   alu_res = a_q & b_q;
                            FnOr:    alu_res = a_q | b_q;
                            FnSlt:   alu_res = {31'b0, ($signed(a_q) < $signed(b_q))};
                            default: state_d = StHalt;
                        endcase
                    end
                    OpAddi: begin
                        alu_res = a_q + sext_imm;
                        state_d = StWb;
                    end
                    OpLw, OpSw: begin
                        alu_res = a_q + sext_imm;
                        state_d = StMem;
                    end
                    OpBeq: begin
                        retire  = 1'b1;
                        state_d = StFetch;
                        if (a_q == b_q) begin
                            // pc_q already points past the branch
                            pc_load = 1'b1;
                            pc_next = pc_q + ADDR_W'({sext_imm[29:0], 2'b00});
                        end
                    end
                    OpJ: begin
                        retire  = 1'b1;
                        state_d = StFetch;
                        pc_load = 1'b1;
                        pc_next = ADDR_W'((32'(pc_q) & 32'hF000_0000)
                                          | {4'b0, ir_q[25:0], 2'b00});
                    end
                    default: state_d = StHalt;
                endcase
            end
            StMem: begin
                mem.MemReq  = 1'b1;
                mem.MemWr   = (opcode == OpSw);
                mem.MemAddr = alu_q[ADDR_W-1:0];
                if (mem.MemReady) begin
                    if (opcode == OpSw) begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                retire   = 1'b1;
                state_d  = StFetch;
                rf_we    = 1'b1;
                rf_waddr = (opcode == OpRtype) ? rd : rt;
                rf_wdata = (opcode == OpLw) ? mdr_q : alu_q;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: state_d = StHalt;
        endcase
    end

    // FSM state register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers, register file and retire counter
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc_q  <= ADDR_W'(RESET_PC);
            ir_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            alu_q <= '0;
            mdr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            if (state_q == StFetch && mem.MemReady) begin
                ir_q <= mem.MemRData;
                pc_q <= pc_q + ADDR_W'(4);
            end
            if (pc_load) begin
                pc_q <= pc_next;
            end
            if (state_q == StDecode) begin
                a_q <= rf_q[rs];
                b_q <= rf_q[rt];
            end
            if (state_q == StExec) begin
                alu_q <= alu_res;
            end
            if (state_q == StMem && mem.MemReady && opcode == OpLw) begin
                mdr_q <= mem.MemRData;
            end
            // Register 0 is never written, so it always reads as zero
            if (rf_we && rf_waddr != 5'd0) begin
                rf_q[rf_waddr] <= rf_wdata;
            end
            if (retire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Self-checking bench for multi_cycle_cpu: a word memory model, a store scoreboard
// and one task per scenario.
module tb_multi_cycle_cpu;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        ready = 1'b1;
    logic        Halted;
    logic [31:0] RetireCnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q [$];
    wr_t         got;
    logic [31:0] prog  [$];
    logic [31:0] mem   [0:255];

    multi_cycle_cpu_if #(.ADDR_W(16)) bus ();

    multi_cycle_cpu #(
        .ADDR_W   (16),
        .RESET_PC (0),
        .CNT_W    (32)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .mem       (bus),
        .Halted    (Halted),
        .RetireCnt (RetireCnt)
    );

    always #5 Clock = ~Clock;

    assign bus.MemReady = ready;
    assign bus.MemRData = mem[bus.MemAddr[9:2]];

    // Memory model write port
    always @(posedge Clock) begin
        if (!Reset && bus.MemReq === 1'b1 && bus.MemWr === 1'b1 && ready) begin
            mem[bus.MemAddr[9:2]] <= bus.MemWData;
        end
    end

    // Store scoreboard: every completing write must match the oldest expected store
    always @(negedge Clock) begin
        if (!Reset && bus.MemReq === 1'b1 && bus.MemWr === 1'b1 && ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL store_unexpected: got addr=%h data=%h, required no store",
                         bus.MemAddr, bus.MemWData);
            end else begin
                got = exp_q.pop_front();
                if (bus.MemAddr !== got.addr || bus.MemWData !== got.data) begin
                    bad++;
                    $display("FAIL store_match: got addr=%h data=%h, required addr=%h data=%h",
                             bus.MemAddr, bus.MemWData, got.addr, got.data);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] i_type(input logic [5:0] op, input int rs, input int rt,
                                           input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] r_type(input logic [5:0] fn, input int rd, input int rs,
                                           input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    // Hold reset for two edges, load prog[] at address 0, release with MemReady=1
    task automatic start_prog();
        @(posedge Clock);
        #1 Reset = 1'b1;
        ready = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int i = 0; i < prog.size(); i++) mem[i] = prog[i];
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
    endtask

    task automatic wait_halt(input int max_cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge Clock);
            if (Halted === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL halt_timeout: Halted=%b after %0d cycles, required 1", Halted,
                     max_cycles);
        end
    endtask

    task automatic check_drained(input string name);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drained: %0d stores outstanding, required 0", name,
                     exp_q.size());
        end
    endtask

    task automatic test_reset();
        prog = {32'hFC00_0000};
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = prog[0];
        @(posedge Clock);
        #1 Reset = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        total += 5;
        if (bus.MemReq !== 1'b1) begin bad++; $display("FAIL rst_req: got %b, required 1", bus.MemReq); end
        if (bus.MemWr !== 1'b0) begin bad++; $display("FAIL rst_wr: got %b, required 0", bus.MemWr); end
        if (bus.MemAddr !== 16'h0) begin bad++; $display("FAIL rst_addr: got %h, required 0000", bus.MemAddr); end
        if (Halted !== 1'b0) begin bad++; $display("FAIL rst_halted: got %b, required 0", Halted); end
        if (RetireCnt !== 32'd0) begin bad++; $display("FAIL rst_cnt: got %0d, required 0", RetireCnt); end
        @(posedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
        total += 2;
        if (bus.MemReq !== 1'b1 || bus.MemWr !== 1'b0) begin
            bad++;
            $display("FAIL first_fetch_req: got req=%b wr=%b, required 1 0", bus.MemReq, bus.MemWr);
        end
        if (bus.MemAddr !== 16'h0) begin bad++; $display("FAIL first_fetch_addr: got %h, required 0000", bus.MemAddr); end
    endtask

    task automatic test_arith();
        prog = {};
        prog.push_back(i_type(6'h08, 0, 1, 16'd5));
        prog.push_back(i_type(6'h08, 0, 2, 16'd7));
        prog.push_back(r_type(6'h20, 3, 1, 2));
        prog.push_back(r_type(6'h22, 5, 1, 2));
        prog.push_back(r_type(6'h24, 6, 1, 2));
        prog.push_back(r_type(6'h25, 7, 1, 2));
        prog.push_back(r_type(6'h2A, 8, 5, 1));
        prog.push_back(r_type(6'h2A, 9, 1, 5));
        prog.push_back(i_type(6'h04, 1, 2, 16'd5));     // not taken
        prog.push_back(i_type(6'h04, 0, 0, 16'd1));     // taken, skips next
        prog.push_back(i_type(6'h08, 0, 10, 16'd99));
        prog.push_back(i_type(6'h08, 0, 10, 16'hFFFF));
        prog.push_back(i_type(6'h08, 0, 0, 16'd9));     // write to $0 discarded
        prog.push_back(i_type(6'h2B, 0, 3, 16'h100));
        prog.push_back(i_type(6'h2B, 0, 5, 16'h104));
        prog.push_back(i_type(6'h2B, 0, 6, 16'h108));
        prog.push_back(i_type(6'h2B, 0, 7, 16'h10C));
        prog.push_back(i_type(6'h2B, 0, 8, 16'h110));
        prog.push_back(i_type(6'h2B, 0, 9, 16'h114));
        prog.push_back(i_type(6'h2B, 0, 10, 16'h118));
        prog.push_back(i_type(6'h2B, 0, 0, 16'h11C));
        prog.push_back(32'hFC00_0000);
        start_prog();
        exp_q.push_back('{16'h100, 32'd12});
        exp_q.push_back('{16'h104, 32'hFFFF_FFFE});
        exp_q.push_back('{16'h108, 32'd5});
        exp_q.push_back('{16'h10C, 32'd7});
        exp_q.push_back('{16'h110, 32'd1});
        exp_q.push_back('{16'h114, 32'd0});
        exp_q.push_back('{16'h118, 32'hFFFF_FFFF});
        exp_q.push_back('{16'h11C, 32'd0});
        repeat (11) @(posedge Clock);
        @(negedge Clock);
        total++;
        if (RetireCnt !== 32'd2) begin bad++; $display("FAIL arith_cnt11: got %0d, required 2", RetireCnt); end
        @(posedge Clock);
        @(negedge Clock);
        total++;
        if (RetireCnt !== 32'd3) begin bad++; $display("FAIL arith_cnt12: got %0d, required 3", RetireCnt); end
        wait_halt(400);
        total += 2;
        if (RetireCnt !== 32'd20) begin bad++; $display("FAIL arith_final_cnt: got %0d, required 20", RetireCnt); end
        if (bus.MemReq !== 1'b0) begin bad++; $display("FAIL arith_halt_req: got %b, required 0", bus.MemReq); end
        check_drained("arith");
    endtask

    task automatic test_jump_mem();
        int exp_cnt;
        prog = {};
        prog.push_back({6'h02, 26'h10});
        while (prog.size() < 16) prog.push_back(32'h0);
        prog.push_back(i_type(6'h08, 0, 3, 16'd12));
        prog.push_back(i_type(6'h2B, 0, 3, 16'd8));
        prog.push_back(i_type(6'h23, 0, 4, 16'd8));
        prog.push_back(i_type(6'h2B, 0, 4, 16'h120));
        prog.push_back(32'hFC00_0000);
        start_prog();
        exp_q.push_back('{16'h0008, 32'd12});
        exp_q.push_back('{16'h0120, 32'd12});
        // Retire edges: j@3, addi@7, sw@11, lw@16
        for (int k = 1; k <= 16; k++) begin
            @(posedge Clock);
            @(negedge Clock);
            exp_cnt = int'(k >= 3) + int'(k >= 7) + int'(k >= 11) + int'(k >= 16);
            total++;
            if (RetireCnt !== 32'(exp_cnt)) begin
                bad++;
                $display("FAIL latency_cnt_edge%0d: got %0d, required %0d", k, RetireCnt, exp_cnt);
            end
            if (k == 3) begin
                total++;
                if (bus.MemAddr !== 16'h0040) begin bad++; $display("FAIL jump_target: got %h, required 0040", bus.MemAddr); end
            end
        end
        wait_halt(100);
        total++;
        if (RetireCnt !== 32'd5) begin bad++; $display("FAIL jm_final_cnt: got %0d, required 5", RetireCnt); end
        check_drained("jump_mem");
    endtask

    task automatic test_branch_loop();
        prog = {i_type(6'h08, 0, 1, 16'd3), i_type(6'h04, 1, 1, 16'hFFFF)};
        start_prog();
        repeat (4) @(posedge Clock);
        for (int m = 0; m < 5; m++) begin
            if (m > 0) repeat (3) @(posedge Clock);
            @(negedge Clock);
            total += 2;
            if (bus.MemReq !== 1'b1 || bus.MemAddr !== 16'h0004) begin
                bad++;
                $display("FAIL loop_fetch%0d: got req=%b addr=%h, required 1 0004", m, bus.MemReq, bus.MemAddr);
            end
            if (RetireCnt !== 32'(m + 1)) begin
                bad++;
                $display("FAIL loop_cnt%0d: got %0d, required %0d", m, RetireCnt, m + 1);
            end
        end
    endtask

    task automatic test_fetch_stall();
        prog = {i_type(6'h08, 0, 1, 16'd5), 32'hFC00_0000};
        start_prog();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            total++;
            if (bus.MemReq !== 1'b1 || bus.MemAddr !== 16'h0) begin
                bad++;
                $display("FAIL stall_addr%0d: got req=%b addr=%h, required 1 0000", i, bus.MemReq, bus.MemAddr);
            end
            @(posedge Clock);
        end
        #1 ready = 1'b1;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        total++;
        if (RetireCnt !== 32'd0) begin bad++; $display("FAIL stall_cnt6: got %0d, required 0", RetireCnt); end
        @(posedge Clock);
        @(negedge Clock);
        total++;
        if (RetireCnt !== 32'd1) begin bad++; $display("FAIL stall_cnt7: got %0d, required 1", RetireCnt); end
    endtask

    task automatic test_halt();
        logic [31:0] halt_words [3];
        halt_words[0] = 32'hFC00_0000;
        halt_words[1] = r_type(6'h21, 3, 1, 1);
        halt_words[2] = {6'h05, 26'h0};
        for (int w = 0; w < 3; w++) begin
            prog = {i_type(6'h08, 0, 1, 16'd5), halt_words[w], i_type(6'h2B, 0, 1, 16'h130)};
            start_prog();
            repeat (6) @(posedge Clock);
            @(negedge Clock);
            total++;
            if (Halted !== 1'b0) begin bad++; $display("FAIL halt%0d_early: got %b, required 0", w, Halted); end
            @(posedge Clock);
            @(negedge Clock);
            total++;
            if (Halted !== 1'b1 || bus.MemReq !== 1'b0 || RetireCnt !== 32'd1) begin
                bad++;
                $display("FAIL halt%0d_enter: got halted=%b req=%b cnt=%0d, required 1 0 1", w, Halted, bus.MemReq, RetireCnt);
            end
            repeat (5) @(posedge Clock);
            @(negedge Clock);
            total++;
            if (Halted !== 1'b1 || bus.MemReq !== 1'b0 || RetireCnt !== 32'd1) begin
                bad++;
                $display("FAIL halt%0d_hold: got halted=%b req=%b cnt=%0d, required 1 0 1", w, Halted, bus.MemReq, RetireCnt);
            end
        end
    endtask

    task automatic test_reset_in_mem();
        prog = {i_type(6'h08, 0, 1, 16'd5), i_type(6'h2B, 0, 1, 16'h140), 32'hFC00_0000};
        start_prog();
        repeat (6) @(posedge Clock);
        #1 ready = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        total++;
        if (bus.MemReq !== 1'b1 || bus.MemWr !== 1'b1 || bus.MemAddr !== 16'h0140
            || bus.MemWData !== 32'd5) begin
            bad++;
            $display("FAIL mem_stall: got req=%b wr=%b addr=%h wdata=%h, required 1 1 0140 00000005",
                     bus.MemReq, bus.MemWr, bus.MemAddr, bus.MemWData);
        end
        @(posedge Clock);
        #1 Reset = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        total += 2;
        if (bus.MemReq !== 1'b1 || bus.MemWr !== 1'b0 || bus.MemAddr !== 16'h0) begin
            bad++;
            $display("FAIL abort_fetch: got req=%b wr=%b addr=%h, required 1 0 0000", bus.MemReq, bus.MemWr, bus.MemAddr);
        end
        if (RetireCnt !== 32'd0 || mem[80] !== 32'h0) begin
            bad++;
            $display("FAIL abort_state: got cnt=%0d mem=%h, required 0 00000000", RetireCnt, mem[80]);
        end
        @(posedge Clock);
        #1 Reset = 1'b0;
        ready = 1'b1;
        exp_q.push_back('{16'h0140, 32'd5});
        wait_halt(100);
        total++;
        if (RetireCnt !== 32'd2) begin bad++; $display("FAIL rerun_cnt: got %0d, required 2", RetireCnt); end
        check_drained("reset_mem");
    endtask

    initial begin
        test_reset();
        test_arith();
        test_jump_mem();
        test_branch_loop();
        test_fetch_stall();
        test_halt();
        test_reset_in_mem();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_cycle_cpu.md
MULTI_CYCLE_CPU -- requirements
Module: multi_cycle_cpu

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: width of PC and MemAddr (byte address).
REQ-002 SHALL have parameter RESET_PC, default 0: PC value loaded on reset (word-aligned).
REQ-003 SHALL have parameter CNT_W, default 32: width of RetireCnt.
REQ-004 SHALL have port Clock, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port MemReq, output, 1: memory access request; combinational from state.
REQ-007 SHALL have port MemWr, output, 1: write qualifier for MemReq.
REQ-008 SHALL have port MemAddr, output, ADDR_W: access byte address.
REQ-009 SHALL have port MemWData, output, 32: store data.
REQ-010 SHALL have port MemRData, input, 32: read data, valid when MemReady=1.
REQ-011 SHALL have port MemReady, input, 1: access completes in any cycle with MemReq=1 and MemReady=1.
REQ-012 SHALL have port Halted, output, 1: core stopped.
REQ-013 SHALL have port RetireCnt, output, CNT_W: count of retired instructions.

Function
REQ-014 SHALL hold 32x32 register file; reg 0 reads 0, writes to it discarded.
REQ-015 SHALL use FSM states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-016 FETCH: MemReq=1, MemWr=0, MemAddr=PC; hold until MemReady=1; then IR<=MemRData, PC<=PC+4, go DECODE.
REQ-017 DECODE: A<=R[rs], B<=R[rt]; decode opcode IR[31:26]; go EXEC (one cycle).
REQ-018 EXEC, opcode 0x00 (R-type), funct IR[5:0]: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed slt; ALUOut<=result; go WB; unknown funct -> HALT.
REQ-019 EXEC, 0x08 addi: ALUOut<=A+sext(imm16); go WB.
REQ-020 EXEC, 0x23 lw / 0x2B sw: ALUOut<=A+sext(imm16); go MEM.
REQ-021 EXEC, 0x04 beq: if A==B, PC<=PC+(sext(imm16)<<2) (PC already incremented); retire; go FETCH.
REQ-022 EXEC, 0x02 j: PC<={PC[ADDR_W-1:28] if ADDR_W>28, IR[25:0],2'b00} truncated to ADDR_W; retire; go FETCH.
REQ-023 EXEC, 0x3F or any other opcode: go HALT; not retired.
REQ-024 MEM: MemReq=1, MemAddr=ALUOut[ADDR_W-1:0], MemWr=1 for sw with MemWData=B; hold until MemReady=1; lw: MDR<=MemRData, go WB; sw: retire, go FETCH.
REQ-025 WB: R-type writes ALUOut to rd; addi writes ALUOut to rt; lw writes MDR to rt; retire; go FETCH.
REQ-026 MemReq SHALL be 0 in DECODE, EXEC, WB, HALT; MemWr SHALL be 0 whenever MemReq=0.
REQ-027 Arithmetic SHALL be 32-bit modulo 2^32, no overflow trap; PC arithmetic modulo 2^ADDR_W.
REQ-028 Latency with MemReady tied 1: R-type/addi 4, lw 5, sw 4, beq/j 3 cycles; each MemReady=0 cycle in FETCH/MEM adds 1.
REQ-029 RetireCnt SHALL increment by 1 on the retiring edge, wrapping at 2^CNT_W-1 to 0.
REQ-030 HALT: Halted=1, no state changes, no memory requests, until Reset.

Reset
REQ-031 Reset=1 at a rising edge SHALL set state FETCH, PC=RESET_PC, all registers, IR, A, B, ALUOut, MDR to 0, RetireCnt=0, Halted=0; it overrides all other activity, including a pending MEM access (abandoned, no write completed).
REQ-032 First cycle after reset: MemReq=1, MemWr=0, MemAddr=RESET_PC.

Verification
REQ-033 Reset, memory 0x0: addi $1,$0,5; addi $2,$0,7; add $3,$1,$2 with MemReady=1 -> R3=12, RetireCnt=3 after 12 cycles.
REQ-034 sw $3,8($0) then lw $4,8($0) -> one write MemAddr=8 MemWData=12, R4=12; lw takes 5 cycles.
REQ-035 beq $1,$1,-1 -> PC returns to branch address each 3 cycles; RetireCnt increments per loop.
REQ-036 MemReady low 3 cycles in FETCH -> MemAddr stable, instruction latency +3.
REQ-037 Opcode 0x3F -> Halted=1, MemReq=0, RetireCnt frozen; Reset asserted during an sw MEM stall -> no write, MemAddr=RESET_PC next cycle.
